// File: rtl/fetch_control_unit.sv
// fetch_control_unit: multi-cycle fetch/decode/sequencer driving the 4-bit datapath
// Ports: clk/rst (sync, active-high); start, load_en/load_addr/load_data (honoured in IDLE/HALT only);
//        instruction/opcode/binv/rw feed the datapath; pc, busy, halted, retired report progress.
module fetch_control_unit #(
    parameter int IMEM_DEPTH = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load_en,
    input  logic [3:0]       load_addr,
    input  logic [15:0]      load_data,
    output logic [15:0]      instruction,
    output logic [1:0]       opcode,
    output logic             binv,
    output logic             rw,
    output logic [3:0]       pc,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, READ, EXEC, WRITE, NEXT, HALT} state_t;
    state_t state, state_nxt;
    logic [15:0] imem [IMEM_DEPTH];
    logic parked, do_load, do_start;
    assign parked   = (state == IDLE) || (state == HALT);
    assign do_load  = parked && load_en;
    assign do_start = parked && start && !load_en;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALT: state_nxt = do_start ? FETCH : state;
            FETCH:      state_nxt = DECODE;
            DECODE:     state_nxt = (instruction[15:12] == 4'h1) ? READ :
                                    (instruction[15:12] == 4'hF) ? HALT : NEXT;
            READ:       state_nxt = EXEC;
            EXEC:       state_nxt = WRITE;
            WRITE:      state_nxt = NEXT;
            NEXT:       state_nxt = FETCH;
            default:    state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= 16'h0000;
            instruction <= 16'h0000;
            opcode      <= 2'b00;
            binv        <= 1'b0;
            rw          <= 1'b1;
            pc          <= 4'd0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            retired     <= '0;
        end else begin
            if (do_load) imem[load_addr] <= load_data;
            if (do_start) begin
                pc      <= 4'd0;
                retired <= '0;
            end
            if (state == FETCH) instruction <= imem[pc];
            if (state == DECODE) begin
                opcode <= instruction[7:6];
                binv   <= instruction[8];
            end
            if (state == NEXT) begin
                pc      <= pc + 4'd1;
                retired <= (&retired) ? retired : retired + CNT_W'(1);
            end
            rw     <= state_nxt != WRITE;
            busy   <= !(state_nxt inside {IDLE, HALT});
            halted <= state_nxt == HALT;
        end
    end
endmodule
